// File: rtl/countdown_clock_if.sv
// Command, pixel and status signals of the MM:SS countdown clock.
// The slave modport is the clock itself; the master modport is its controller.
interface countdown_clock_if;
  logic        load;
  logic [15:0] load_digits;
  logic        start;
  logic        stop;
  logic [10:0] x;
  logic [9:0]  y;
  logic [15:0] digits;
  logic        running;
  logic        expire;
  logic        warn;
  logic        in_box;
  logic [8:0]  rom_base_addr;

  modport master (
    output load, load_digits, start, stop, x, y,
    input  digits, running, expire, warn, in_box, rom_base_addr
  );

  modport slave (
    input  load, load_digits, start, stop, x, y,
    output digits, running, expire, warn, in_box, rom_base_addr
  );
endinterface

// File: rtl/countdown_clock.sv
// Four-digit BCD MM:SS countdown clock with one-second prescaler and char-ROM lookup.
// Optional low-time warning output is built only when COUNTDOWN_WARN_EN is defined.
module countdown_clock #(
  parameter logic [19:0] TICK_DIV = 20'd1000000,
  parameter logic [10:0] X_BOX    = 11'd0,
  parameter logic [9:0]  Y_BOX    = 10'd0,
  parameter logic [10:0] CELL_W   = 11'd8
) (
  input  logic              clk,
  input  logic              rst,
  countdown_clock_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_digits;
  logic [15:0] w_digits_nxt;
  logic [19:0] r_presc;
  logic [19:0] w_presc_nxt;
  logic        r_expire;
  logic        w_expire_nxt;

  logic        w_tick;
  logic [15:0] w_dec;
  logic [15:0] w_clamped;
  logic        w_b0;
  logic        w_b1;
  logic        w_b2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_digits <= 16'h0000;
      r_presc  <= 20'd0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_presc  <= w_presc_nxt;
      r_expire <= w_expire_nxt;
    end
  end

  always_comb begin
    w_clamped[15:12] = (bus.load_digits[15:12] > 4'd9) ? 4'd9 : bus.load_digits[15:12];
    w_clamped[11:8]  = (bus.load_digits[11:8]  > 4'd9) ? 4'd9 : bus.load_digits[11:8];
    w_clamped[7:4]   = (bus.load_digits[7:4]   > 4'd5) ? 4'd5 : bus.load_digits[7:4];
    w_clamped[3:0]   = (bus.load_digits[3:0]   > 4'd9) ? 4'd9 : bus.load_digits[3:0];
  end

  // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
  always_comb begin
    w_dec      = r_digits;
    w_b0       = (r_digits[3:0] == 4'd0);
    w_dec[3:0] = w_b0 ? 4'd9 : r_digits[3:0] - 4'd1;
    w_b1       = w_b0 && (r_digits[7:4] == 4'd0);
    if (w_b0) w_dec[7:4] = (r_digits[7:4] == 4'd0) ? 4'd5 : r_digits[7:4] - 4'd1;
    w_b2       = w_b1 && (r_digits[11:8] == 4'd0);
    if (w_b1) w_dec[11:8] = (r_digits[11:8] == 4'd0) ? 4'd9 : r_digits[11:8] - 4'd1;
    if (w_b2) w_dec[15:12] = r_digits[15:12] - 4'd1;
  end

  assign w_tick = (r_state == ST_RUN) && (r_presc == TICK_DIV - 20'd1);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_presc_nxt  = r_presc;
    w_expire_nxt = 1'b0;

    if (bus.load) begin
      w_state_nxt  = ST_IDLE;
      w_digits_nxt = w_clamped;
      w_presc_nxt  = 20'd0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_PAUSE: begin
          // Stop outranks start even where stop itself has no effect.
          if (bus.start && !bus.stop)
            w_state_nxt = (r_digits == 16'h0000) ? ST_EXPIRED : ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop) w_state_nxt = ST_PAUSE;
          if (w_tick) begin
            w_presc_nxt  = 20'd0;
            w_digits_nxt = w_dec;
            if (w_dec == 16'h0000) begin
              w_state_nxt  = ST_EXPIRED;
              w_expire_nxt = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 20'd1;
          end
        end
        ST_EXPIRED: ;
        default: ;
      endcase
    end
  end

  assign bus.digits  = r_digits;
  assign bus.running = (r_state == ST_RUN);
  assign bus.expire  = r_expire;

`ifdef COUNTDOWN_WARN_EN
  assign bus.warn = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) && (r_digits <= 16'h0010);
`else
  assign bus.warn = 1'b0;
`endif

  logic       w_y_in;
  logic       w_in_box;
  logic [8:0] w_rom_addr;

  always_comb begin
    w_y_in     = ({1'b0, bus.y} >= {1'b0, Y_BOX}) &&
                 ({1'b0, bus.y} <  {1'b0, Y_BOX} + 11'd8);
    w_in_box   = 1'b0;
    w_rom_addr = 9'h000;
    for (int i = 0; i < 4; i++) begin
      if (w_y_in &&
          (bus.x >= X_BOX + CELL_W * 11'(i)) &&
          (bus.x <  X_BOX + CELL_W * 11'(i + 1))) begin
        w_in_box   = 1'b1;
        w_rom_addr = {2'b00, r_digits[15 - 4*i -: 4], 3'b000} + 9'h180;
      end
    end
  end

  assign bus.in_box        = w_in_box;
  assign bus.rom_base_addr = w_rom_addr;

endmodule

// File: tb/tb_countdown_clock.sv
// Scoreboard bench for countdown_clock: expectations are queued when stimulus
// is applied and popped when the corresponding output is sampled.
module tb_countdown_clock;

  localparam logic [19:0] TICK_DIV = 20'd4;
  localparam logic [10:0] X_BOX    = 11'd100;
  localparam logic [9:0]  Y_BOX    = 10'd0;
  localparam logic [10:0] CELL_W   = 11'd8;
`ifdef COUNTDOWN_WARN_EN
  localparam logic WARN_ON = 1'b1;
`else
  localparam logic WARN_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  countdown_clock_if u_if ();

  countdown_clock #(
    .TICK_DIV (TICK_DIV),
    .X_BOX    (X_BOX),
    .Y_BOX    (Y_BOX),
    .CELL_W   (CELL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic expect_core(input string tag, input logic [15:0] d, input logic r, input logic e);
    push({tag, ".digits"},  {16'h0, d});
    push({tag, ".running"}, {31'h0, r});
    push({tag, ".expire"},  {31'h0, e});
  endtask

  task automatic sample_core();
    pop_check({16'h0, u_if.digits});
    pop_check({31'h0, u_if.running});
    pop_check({31'h0, u_if.expire});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    u_if.load = 1'b1;
    u_if.load_digits = v;
    step();
    u_if.load = 1'b0;
  endtask

  task automatic do_start();
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
  endtask

  // Queue n cycles of a running countdown from value d0 with tick every TICK_DIV edges.
  task automatic expect_run(input string tag, input logic [15:0] d_seq[4], input int n);
    for (int k = 0; k < n; k++)
      expect_core($sformatf("%s[%0d]", tag, k), d_seq[k / int'(TICK_DIV)], 1'b1, 1'b0);
  endtask

  task automatic expect_display(input string tag, input logic [10:0] x, input logic [9:0] y,
                                input logic ib, input logic [8:0] addr);
    u_if.x = x;
    u_if.y = y;
    push({tag, ".in_box"}, {31'h0, ib});
    push({tag, ".addr"},   {23'h0, addr});
    #1;
    pop_check({31'h0, u_if.in_box});
    pop_check({23'h0, u_if.rom_base_addr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] seq[4];
    rst = 1'b0;
    u_if.load = 1'b0;
    u_if.load_digits = 16'h0000;
    u_if.start = 1'b0;
    u_if.stop = 1'b0;
    u_if.x = 11'd0;
    u_if.y = 10'd0;

    // Reset and release.
    expect_core("rst_held", 16'h0000, 1'b0, 1'b0);
    #12;
    sample_core();
    rst = 1'b1;
    expect_core("rst_rel", 16'h0000, 1'b0, 1'b0);
    push("rst_rel.warn", 32'd0);
    step();
    sample_core();
    pop_check({31'h0, u_if.warn});

    // 01:02 countdown across a seconds borrow.
    expect_core("ld0102", 16'h0102, 1'b0, 1'b0);
    do_load(16'h0102);
    sample_core();
    seq = '{16'h0102, 16'h0101, 16'h0100, 16'h0059};
    expect_run("run0102", seq, 13);
    do_start();
    sample_core();
    for (int k = 0; k < 12; k++) begin
      step();
      sample_core();
    end

    // Asynchronous reset mid-RUN.
    step();
    rst = 1'b0;
    expect_core("rst_mid", 16'h0000, 1'b0, 1'b0);
    #2;
    sample_core();
    #2;
    rst = 1'b1;
    step();

    // 10:00 borrow across three digits.
    expect_core("ld1000", 16'h1000, 1'b0, 1'b0);
    do_load(16'h1000);
    sample_core();
    seq = '{16'h1000, 16'h0959, 16'h0959, 16'h0959};
    expect_run("run1000", seq, 5);
    do_start();
    sample_core();
    for (int k = 0; k < 4; k++) begin
      step();
      sample_core();
    end

    // Terminal tick: one-cycle expire, then start/stop are ignored.
    expect_core("ld0001", 16'h0001, 1'b0, 1'b0);
    do_load(16'h0001);
    sample_core();
    seq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    expect_run("run0001", seq, 4);
    expect_core("expire_hit",  16'h0000, 1'b0, 1'b1);
    expect_core("expire_drop", 16'h0000, 1'b0, 1'b0);
    expect_core("exp_start",   16'h0000, 1'b0, 1'b0);
    expect_core("exp_stop",    16'h0000, 1'b0, 1'b0);
    do_start();
    sample_core();
    for (int k = 0; k < 5; k++) begin
      step();
      sample_core();
    end
    do_start();
    sample_core();
    u_if.stop = 1'b1;
    step();
    u_if.stop = 1'b0;
    sample_core();

    // Start at 00:00 goes straight to EXPIRED without a pulse.
    expect_core("ld0000",    16'h0000, 1'b0, 1'b0);
    expect_core("start_zero", 16'h0000, 1'b0, 1'b0);
    do_load(16'h0000);
    sample_core();
    do_start();
    sample_core();

    // Clamped preset, stop+start pause, resume keeps prescaler phase.
    expect_core("ld_clamp", 16'h9959, 1'b0, 1'b0);
    do_load(16'hFF7A);
    sample_core();
    expect_core("cl_start",  16'h9959, 1'b1, 1'b0);
    expect_core("cl_run1",   16'h9959, 1'b1, 1'b0);
    expect_core("cl_pause",  16'h9959, 1'b0, 1'b0);
    expect_core("cl_hold1",  16'h9959, 1'b0, 1'b0);
    expect_core("cl_hold2",  16'h9959, 1'b0, 1'b0);
    expect_core("cl_resume", 16'h9959, 1'b1, 1'b0);
    expect_core("cl_pre",    16'h9959, 1'b1, 1'b0);
    expect_core("cl_tick",   16'h9958, 1'b1, 1'b0);
    do_start();
    sample_core();
    step();
    sample_core();
    u_if.stop = 1'b1;
    u_if.start = 1'b1;
    step();
    u_if.stop = 1'b0;
    u_if.start = 1'b0;
    sample_core();
    step();
    sample_core();
    step();
    sample_core();
    do_start();
    sample_core();
    step();
    sample_core();
    step();
    sample_core();

    // Display lookup on 01:23.
    expect_core("ld0123", 16'h0123, 1'b0, 1'b0);
    do_load(16'h0123);
    sample_core();
    expect_display("disp_x117",   11'd117, 10'd3, 1'b1, 9'h190);
    expect_display("disp_x132",   11'd132, 10'd3, 1'b0, 9'h000);
    expect_display("disp_x100",   11'd100, 10'd0, 1'b1, 9'h180);
    expect_display("disp_x131",   11'd131, 10'd7, 1'b1, 9'h198);
    expect_display("disp_x99",    11'd99,  10'd3, 1'b0, 9'h000);
    expect_display("disp_y8",     11'd117, 10'd8, 1'b0, 9'h000);
    u_if.x = 11'd0;
    u_if.y = 10'd0;

    // Low-time warning around 00:10.
    expect_core("ld0011", 16'h0011, 1'b0, 1'b0);
    push("warn_0011_idle", 32'd0);
    do_load(16'h0011);
    sample_core();
    pop_check({31'h0, u_if.warn});
    push("warn_0011_run", 32'd0);
    do_start();
    pop_check({31'h0, u_if.warn});
    for (int k = 0; k < 3; k++) step();
    push("warn_0010_digits", 32'h0010);
    push("warn_0010_run", {31'h0, WARN_ON});
    step();
    pop_check({16'h0, u_if.digits});
    pop_check({31'h0, u_if.warn});
    push("warn_after_load", 32'd0);
    do_load(16'h0000);
    pop_check({31'h0, u_if.warn});

    check("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
